// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: MD op encoding,
// default latencies and the busy-counter sizing helper.
package mdu_sequencer_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int unsigned MD_OP_W          = 3;
    localparam int unsigned MD_DATA_W        = 32;
    localparam int unsigned MULT_CYCLES_DEF  = 5;
    localparam int unsigned DIV_CYCLES_DEF   = 10;

    // Counter must hold the longer latency, never narrower than 4 bits.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/mdu_sequencer_md_arith.sv
// Combinational MD datapath: 64-bit signed/unsigned product, quotient and
// remainder, plus a flag for a divide whose divisor is zero.
module md_arith
    import mdu_sequencer_pkg::*;
(
    input  logic [MD_OP_W-1:0]   md_op,
    input  logic [MD_DATA_W-1:0] rs,
    input  logic [MD_DATA_W-1:0] rt,
    output logic [MD_DATA_W-1:0] hi_c,
    output logic [MD_DATA_W-1:0] lo_c,
    output logic                 div_zero_c
);

    logic signed [63:0]          s_prod;
    logic        [63:0]          u_prod;
    logic        [MD_DATA_W-1:0] divisor;
    logic signed [MD_DATA_W-1:0] s_quo;
    logic signed [MD_DATA_W-1:0] s_rem;
    logic        [MD_DATA_W-1:0] u_quo;
    logic        [MD_DATA_W-1:0] u_rem;
    logic                        rt_zero;

    assign rt_zero = (rt == '0);
    // Substitute a harmless divisor so the dividers never see zero.
    assign divisor = rt_zero ? 32'd1 : rt;

    assign s_prod = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign u_prod = {32'd0, rs} * {32'd0, rt};
    assign s_quo  = $signed(rs) / $signed(divisor);
    assign s_rem  = $signed(rs) % $signed(divisor);
    assign u_quo  = rs / divisor;
    assign u_rem  = rs % divisor;

    always_comb begin
        hi_c       = '0;
        lo_c       = '0;
        div_zero_c = 1'b0;
        case (md_op)
            MD_MULT: begin
                hi_c = s_prod[63:32];
                lo_c = s_prod[31:0];
            end
            MD_MULTU: begin
                hi_c = u_prod[63:32];
                lo_c = u_prod[31:0];
            end
            MD_DIV: begin
                hi_c       = s_rem;
                lo_c       = s_quo;
                div_zero_c = rt_zero;
            end
            MD_DIVU: begin
                hi_c       = u_rem;
                lo_c       = u_quo;
                div_zero_c = rt_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Execute-stage MD sequencer: owns HI/LO, models fixed mult/div latency with a
// busy counter and raises the D-stage stall while the unit is occupied.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MD_OP_W-1:0]   e_md_op,
    input  logic [MD_DATA_W-1:0] e_rs,
    input  logic [MD_DATA_W-1:0] e_rt,
    input  logic                 d_is_md,
    output logic                 start,
    output logic                 busy,
    output logic [MD_DATA_W-1:0] hi,
    output logic [MD_DATA_W-1:0] lo,
    output logic                 md_stall
);

    localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                 state;
    logic [CNT_W-1:0]       cnt;
    logic [MD_DATA_W-1:0]   pend_hi;
    logic [MD_DATA_W-1:0]   pend_lo;
    logic                   pend_wr;

    logic [MD_DATA_W-1:0]   res_hi_c;
    logic [MD_DATA_W-1:0]   res_lo_c;
    logic                   div_zero_c;
    logic                   is_mul_c;
    logic                   is_div_c;

    md_arith u_md_arith (
        .md_op      (e_md_op),
        .rs         (e_rs),
        .rt         (e_rt),
        .hi_c       (res_hi_c),
        .lo_c       (res_lo_c),
        .div_zero_c (div_zero_c)
    );

    assign is_mul_c = (e_md_op == MD_MULT) || (e_md_op == MD_MULTU);
    assign is_div_c = (e_md_op == MD_DIV)  || (e_md_op == MD_DIVU);

    assign busy     = (state == S_RUN);
    assign start    = (is_mul_c || is_div_c) && (state == S_IDLE);
    assign md_stall = d_is_md && (start || busy);

    // Result is captured at launch; the counter only models latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        cnt     <= is_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        pend_hi <= res_hi_c;
                        pend_lo <= res_lo_c;
                        pend_wr <= ~div_zero_c;
                    end else if (e_md_op == MD_MTHI) begin
                        hi <= e_rs;
                    end else if (e_md_op == MD_MTLO) begin
                        lo <= e_rs;
                    end
                end
                S_RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
